// File: rtl/lab2_serial_add_ctrl_if.sv
// rtl/lab2_serial_add_ctrl_if.sv - handshake/operand bundle for the nibble-serial adder
// Purpose : groups the request side (start, a, b, cin, optional sub) and the
//           result side (busy, done, sum, cout, ovf) of lab2_serial_add_ctrl.
// Ports   : master modport drives start/a/b/cin/sub and observes results;
//           slave modport (the adder) observes requests and drives results.
// Config  : SERIAL_SUB_EN adds the sub signal to both modports.
interface lab2_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

`ifdef SERIAL_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/lab2_serial_add_ctrl.sv
// rtl/lab2_serial_add_ctrl.sv - nibble-serial W-bit adder reusing one 4-bit adder
// Purpose : adds two W = 4*NIBBLES bit operands one nibble per clock through a
//           single 4-bit adder, carrying between nibbles in a register.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           bus    - lab2_serial_add_ctrl_if.slave (start/a/b/cin[/sub] in,
//                    busy/done/sum/cout/ovf out)
// Config  : SERIAL_SUB_EN - when defined, sub=1 computes A-B (B inverted,
//           initial carry forced to 1, cout=1 means no borrow).

module lab2_nibble_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
endmodule

module lab2_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lab2_serial_add_ctrl_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_busy;
    logic            w_done;
    logic            w_last;

    // Operand registers shift right by one nibble per ADD cycle, so the
    // nibble being added is always in bits [3:0].
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic            r_cout;
    logic            r_ovf;

    logic [W-1:0]    w_eff_b;
    logic            w_init_carry;
    logic [3:0]      w_nib_sum;
    logic            w_nib_cout;
    logic [CW+1:0]   w_base;

`ifdef SERIAL_SUB_EN
    assign w_eff_b      = bus.sub ? ~bus.b : bus.b;
    assign w_init_carry = bus.sub ? 1'b1 : bus.cin;
`else
    assign w_eff_b      = bus.b;
    assign w_init_carry = bus.cin;
`endif

    lab2_nibble_adder u_nib_add (
        .i_a    (r_a[3:0]),
        .i_b    (r_b[3:0]),
        .i_cin  (r_carry),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    assign w_last = (r_cnt == CW'(NIBBLES - 1));
    assign w_base = {r_cnt, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_eff_b;
            r_carry <= w_init_carry;
            r_cnt   <= '0;
        end else if (r_state == S_ADD) begin
            r_a                <= r_a >> 4;
            r_b                <= r_b >> 4;
            r_sum[w_base +: 4] <= w_nib_sum;
            r_carry            <= w_nib_cout;
            // Counter parks on the last index instead of wrapping.
            if (!w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cout <= w_nib_cout;
                // On the last nibble r_a[3]/r_b[3] are the operand sign bits.
                r_ovf  <= (r_a[3] == r_b[3]) && (w_nib_sum[3] != r_a[3]);
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_lab2_serial_add_ctrl.sv
// tb/tb_lab2_serial_add_ctrl.sv - self-checking bench for lab2_serial_add_ctrl
module tb_lab2_serial_add_ctrl;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    lab2_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

    lab2_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: whole-word arithmetic on the effective operands.
    task automatic ref_calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sub, output logic [W-1:0] s, output logic co,
                            output logic ov);
        logic [W:0]   full;
        logic [W-1:0] eb;
        logic         c0;
        logic         use_sub;
`ifdef SERIAL_SUB_EN
        use_sub = sub;
`else
        use_sub = sub & 1'b0;
`endif
        eb   = use_sub ? ~b : b;
        c0   = use_sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, eb} + {{W{1'b0}}, c0};
        s    = full[W-1:0];
        co   = full[W];
        ov   = (a[W-1] == eb[W-1]) && (s[W-1] != a[W-1]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 1 after acceptance; returns the cycle index where done is seen.
    task automatic wait_done(output int cyc, output logic busy_all);
        cyc      = 1;
        busy_all = 1'b1;
        while (!bus.done && cyc < 20) begin
            busy_all &= bus.busy;
            step();
            cyc++;
        end
        busy_all &= bus.busy;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
`ifdef SERIAL_SUB_EN
        bus.sub = sub;
`endif
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input bit scramble);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        int           cyc;
        logic         ball;
        ref_calc(a, b, cin, sub, es, ec, eo);
        drive(a, b, cin, sub);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        if (scramble) drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        wait_done(cyc, ball);
        check({tag, ".latency"}, 32'(cyc), 32'(NIBBLES + 1));
        check({tag, ".busy"}, 32'(ball), 32'd1);
        check({tag, ".sum"}, 32'(bus.sum), 32'(es));
        check({tag, ".cout"}, 32'(bus.cout), 32'(ec));
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(eo));
        step();
        check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".hold_sum"}, 32'(bus.sum), 32'(es));
    endtask

    initial begin
        int           cyc;
        int           ndone;
        logic         ball;
        logic [W-1:0] snap;
        logic         sub_r;
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        drive('0, '0, 1'b0, 1'b0);
        #2;
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.sum", 32'(bus.sum), 32'd0);
        check("reset.cout", 32'(bus.cout), 32'd0);
        check("reset.ovf", 32'(bus.ovf), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        run_op("zero_cin", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);

        // start held high: only re-accepted once back in IDLE
        drive(16'h5A5A, 16'h1234, 1'b0, 1'b0);
        bus.start = 1'b1;
        step();
        wait_done(cyc, ball);
        check("held.latency", 32'(cyc), 32'(NIBBLES + 1));
        check("held.sum", 32'(bus.sum), 32'h6C8E);
        step();
        check("held.idle", 32'(bus.busy), 32'd0);
        step();
        check("held.reaccept", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_done(cyc, ball);
        check("held2.sum", 32'(bus.sum), 32'h6C8E);
        step();

        // start pulsed mid-ADD with new operand is ignored
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.a     = 16'hFFFF;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        ndone = 0;
        snap  = '0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                ndone++;
                snap = bus.sum;
            end
            step();
        end
        check("ignore.pulses", 32'(ndone), 32'd1);
        check("ignore.sum", 32'(snap), 32'h3333);

        // reset in cycle 2 of an operation
        drive(16'h1234, 16'h1111, 1'b0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        check("abort.sum", 32'(bus.sum), 32'd0);
        check("abort.cout", 32'(bus.cout), 32'd0);
        check("abort.ovf", 32'(bus.ovf), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) ndone++;
            step();
        end
        check("abort.no_done", 32'(ndone), 32'd0);
        run_op("after_abort", 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_SUB_EN
        run_op("sub_neg", 16'h0005, 16'h0009, 1'b0, 1'b1, 1'b0);
        check("sub_neg.abs", 32'(bus.sum), 32'hFFFC);
        run_op("sub_pos", 16'h0009, 16'h0005, 1'b0, 1'b1, 1'b0);
        check("sub_pos.abs", 32'(bus.sum), 32'h0004);
        check("sub_pos.cout", 32'(bus.cout), 32'd1);
`endif

        for (int i = 0; i < 24; i++) begin
            sub_r = 1'($urandom);
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), sub_r, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
